// File: rtl/ex_mem_stage_pipe.sv
// EX->MEM pipeline register with valid/ready flow control, optional 2-entry skid, flush and stall counter.
// Latency 1 cycle when empty; SKID=1 registers in_ready (no out_ready->in_ready path), SKID=0 passes it through.
module ex_mem_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int DEST_W = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [DATA_W-1:0]            i_ex_alu_result,
  input  logic                         i_mem_write_en,
  input  logic [DATA_W-1:0]            i_mem_write_data,
  input  logic                         i_write_back_en,
  input  logic [DEST_W-1:0]            i_write_back_dest,
  input  logic                         i_write_back_result_mux,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [2*DATA_W+DEST_W+2:0]   o_out_bundle,
  output logic                         o_out_mem_write_en,
  output logic                         o_out_write_back_en,
  output logic [CNT_W-1:0]             o_stall_cycles
);

  localparam int PKT_W   = 2*DATA_W + DEST_W + 3;
  localparam int MWE_BIT = DEST_W + 2 + DATA_W;
  localparam int WBE_BIT = DEST_W + 1;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PKT_W-1:0]   r_main_pkt;
  logic [PKT_W-1:0]   r_skid_pkt;
  logic [PKT_W-1:0]   w_in_pkt;
  logic [PKT_W-1:0]   w_bundle;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_accept;
  logic               w_drain;
  logic               w_load_main;
  logic               w_load_skid;
  logic               w_promote;

  assign w_in_pkt = {i_ex_alu_result, i_mem_write_en, i_mem_write_data,
                     i_write_back_en, i_write_back_dest, i_write_back_result_mux};

  assign o_out_valid = (r_state != S_EMPTY);
  assign o_in_ready  = (SKID != 0) ? (r_state != S_TWO) : (!o_out_valid || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_drain     = o_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_promote   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_state_nxt = S_ONE;
          w_promote   = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Squash wins over any same-cycle accept or drain; payload regs are left as they are.
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_promote   = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_main_pkt <= '0;
      r_skid_pkt <= '0;
    end else begin
      if (w_load_main) begin
        r_main_pkt <= w_in_pkt;
      end else if (w_promote) begin
        r_main_pkt <= r_skid_pkt;
      end
      if (w_load_skid) begin
        r_skid_pkt <= w_in_pkt;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (o_out_valid && !i_out_ready && !i_flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // A bubble must never carry live enables towards MEM.
  always_comb begin
    w_bundle = r_main_pkt;
    if (!o_out_valid) begin
      w_bundle[MWE_BIT] = 1'b0;
      w_bundle[WBE_BIT] = 1'b0;
    end
  end

  assign o_out_bundle        = w_bundle;
  assign o_out_mem_write_en  = r_main_pkt[MWE_BIT] && o_out_valid;
  assign o_out_write_back_en = r_main_pkt[WBE_BIT] && o_out_valid;
  assign o_stall_cycles      = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_stage_pipe.sv
// Bench for ex_mem_stage_pipe: directed vector table on the default build, queue model on two 32-bit builds.
module tb_ex_mem_stage_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Default build: DATA_W=16, DEST_W=3, SKID=1, CNT_W=16
  logic        d_fl, d_iv, d_rdy, d_mwe, d_wbe, d_mux, d_ov, d_ordy, d_omwe, d_owbe;
  logic [15:0] d_alu, d_mwd, d_st;
  logic [2:0]  d_dest;
  logic [37:0] d_bun;

  ex_mem_stage_pipe u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(d_fl), .i_in_valid(d_iv), .o_in_ready(d_rdy),
    .i_ex_alu_result(d_alu), .i_mem_write_en(d_mwe), .i_mem_write_data(d_mwd),
    .i_write_back_en(d_wbe), .i_write_back_dest(d_dest), .i_write_back_result_mux(d_mux),
    .o_out_valid(d_ov), .i_out_ready(d_ordy), .o_out_bundle(d_bun),
    .o_out_mem_write_en(d_omwe), .o_out_write_back_en(d_owbe), .o_stall_cycles(d_st)
  );

  // Random builds: index 0 is SKID=0, index 1 is SKID=1; DATA_W=32, CNT_W=4
  logic        r_fl [2], r_iv [2], r_rdy [2], r_mwe [2], r_wbe [2], r_mux [2];
  logic        r_ov [2], r_ordy [2], r_omwe [2], r_owbe [2];
  logic [31:0] r_alu [2], r_mwd [2];
  logic [2:0]  r_dest [2];
  logic [69:0] r_bun [2];
  logic [3:0]  r_st [2];

  ex_mem_stage_pipe #(.DATA_W(32), .DEST_W(3), .SKID(0), .CNT_W(4)) u_s0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(r_fl[0]), .i_in_valid(r_iv[0]), .o_in_ready(r_rdy[0]),
    .i_ex_alu_result(r_alu[0]), .i_mem_write_en(r_mwe[0]), .i_mem_write_data(r_mwd[0]),
    .i_write_back_en(r_wbe[0]), .i_write_back_dest(r_dest[0]), .i_write_back_result_mux(r_mux[0]),
    .o_out_valid(r_ov[0]), .i_out_ready(r_ordy[0]), .o_out_bundle(r_bun[0]),
    .o_out_mem_write_en(r_omwe[0]), .o_out_write_back_en(r_owbe[0]), .o_stall_cycles(r_st[0])
  );

  ex_mem_stage_pipe #(.DATA_W(32), .DEST_W(3), .SKID(1), .CNT_W(4)) u_s1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(r_fl[1]), .i_in_valid(r_iv[1]), .o_in_ready(r_rdy[1]),
    .i_ex_alu_result(r_alu[1]), .i_mem_write_en(r_mwe[1]), .i_mem_write_data(r_mwd[1]),
    .i_write_back_en(r_wbe[1]), .i_write_back_dest(r_dest[1]), .i_write_back_result_mux(r_mux[1]),
    .o_out_valid(r_ov[1]), .i_out_ready(r_ordy[1]), .o_out_bundle(r_bun[1]),
    .o_out_mem_write_en(r_omwe[1]), .o_out_write_back_en(r_owbe[1]), .o_stall_cycles(r_st[1])
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [37:0] inpk;
    logic        ordy;
    logic        ev;
    logic        erdy;
    logic [37:0] ebun;
    logic [15:0] est;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] pk16(input logic [15:0] a, input logic mwe, input logic [15:0] d,
                                       input logic wbe, input logic [2:0] dst, input logic mux);
    return {a, mwe, d, wbe, dst, mux};
  endfunction

  function automatic logic [37:0] bub(input logic [37:0] b);
    logic [37:0] r;
    r = b;
    r[21] = 1'b0;
    r[4]  = 1'b0;
    return r;
  endfunction

  task automatic addv(input logic fl, input logic iv, input logic [37:0] inpk, input logic ordy,
                      input logic ev, input logic erdy, input logic [37:0] ebun, input logic [15:0] est);
    vec_t v;
    v.fl = fl; v.iv = iv; v.inpk = inpk; v.ordy = ordy;
    v.ev = ev; v.erdy = erdy; v.ebun = ebun; v.est = est;
    vecs.push_back(v);
  endtask

  // Reference model for the random builds: an ordered queue of at most two entries per build
  logic [69:0] q0[$];
  logic [69:0] q1[$];
  int          cnt [2];
  logic        pend [2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [69:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int k, input logic [69:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  logic [37:0] pa, x1, x2, x3, y1, y2, y3, ps, z1;

  initial begin
    d_fl = 0; d_iv = 0; d_ordy = 0;
    {d_alu, d_mwe, d_mwd, d_wbe, d_dest, d_mux} = '0;
    for (int k = 0; k < 2; k++) begin
      r_fl[k] = 0; r_iv[k] = 0; r_ordy[k] = 0; r_alu[k] = '0; r_mwd[k] = '0;
      r_mwe[k] = 0; r_wbe[k] = 0; r_dest[k] = '0; r_mux[k] = 0;
      cnt[k] = 0; pend[k] = 0;
    end

    pa = pk16(16'h1234, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0);
    x1 = pk16(16'h1111, 1'b0, 16'hA001, 1'b1, 3'd1, 1'b0);
    x2 = pk16(16'h2222, 1'b1, 16'hA002, 1'b0, 3'd2, 1'b1);
    x3 = pk16(16'h3333, 1'b1, 16'hA003, 1'b1, 3'd3, 1'b0);
    y1 = pk16(16'h4444, 1'b1, 16'hB001, 1'b1, 3'd4, 1'b0);
    y2 = pk16(16'h5555, 1'b1, 16'hB002, 1'b1, 3'd5, 1'b1);
    y3 = pk16(16'h6666, 1'b1, 16'hB003, 1'b1, 3'd6, 1'b0);
    ps = pk16(16'h0100, 1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0);
    z1 = pk16(16'h7777, 1'b1, 16'hC001, 1'b1, 3'd7, 1'b1);

    //    fl  iv  payload ordy | ov  rdy bundle    stall
    addv(0, 1, pa, 1,   1, 1, pa,      16'd0);
    addv(0, 0, pa, 1,   0, 1, bub(pa), 16'd0);
    addv(0, 1, x1, 0,   1, 1, x1,      16'd0);
    addv(0, 1, x2, 0,   1, 0, x1,      16'd1);
    addv(0, 1, x3, 0,   1, 0, x1,      16'd2);
    addv(0, 1, x3, 1,   1, 1, x2,      16'd2);
    addv(0, 1, x3, 1,   1, 1, x3,      16'd2);
    addv(0, 0, x3, 1,   0, 1, bub(x3), 16'd2);
    addv(0, 1, y1, 0,   1, 1, y1,      16'd2);
    addv(0, 1, y2, 0,   1, 0, y1,      16'd3);
    addv(1, 1, y3, 0,   0, 1, bub(y1), 16'd3);
    addv(0, 0, y3, 1,   0, 1, bub(y1), 16'd3);
    addv(0, 1, ps, 1,   1, 1, ps,      16'd3);
    addv(0, 0, ps, 1,   0, 1, bub(ps), 16'd3);
    addv(0, 1, z1, 0,   1, 1, z1,      16'd3);
    addv(1, 0, z1, 1,   0, 1, bub(z1), 16'd3);

    repeat (2) @(negedge clk);
    chk("reset out_valid", 128'(d_ov), 128'(1'b0));
    chk("reset bundle", 128'(d_bun), 128'(38'd0));
    chk("reset stall", 128'(d_st), 128'(16'd0));
    rst_n = 1'b1;
    #1;
    chk("release in_ready", 128'(d_rdy), 128'(1'b1));
    chk("release out_valid", 128'(d_ov), 128'(1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      d_fl = vecs[i].fl;
      d_iv = vecs[i].iv;
      d_ordy = vecs[i].ordy;
      {d_alu, d_mwe, d_mwd, d_wbe, d_dest, d_mux} = vecs[i].inpk;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 128'(d_ov), 128'(vecs[i].ev));
      chk($sformatf("vec%0d in_ready", i), 128'(d_rdy), 128'(vecs[i].erdy));
      chk($sformatf("vec%0d bundle", i), 128'(d_bun), 128'(vecs[i].ebun));
      chk($sformatf("vec%0d out_mem_we", i), 128'(d_omwe), 128'(vecs[i].ebun[21]));
      chk($sformatf("vec%0d out_wb_en", i), 128'(d_owbe), 128'(vecs[i].ebun[4]));
      chk($sformatf("vec%0d stall", i), 128'(d_st), 128'(vecs[i].est));
    end

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    d_fl = 0; d_iv = 1; d_ordy = 0;
    {d_alu, d_mwe, d_mwd, d_wbe, d_dest, d_mux} = pa;
    repeat (3) @(posedge clk);
    #1;
    chk("prestall out_valid", 128'(d_ov), 128'(1'b1));
    chk("prestall stall", 128'(d_st), 128'(16'd5));
    @(negedge clk);
    d_iv = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 128'(d_ov), 128'(1'b0));
    chk("midreset stall", 128'(d_st), 128'(16'd0));
    chk("midreset out_wb_en", 128'(d_owbe), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic acc [2];
      logic exp_rdy [2];
      int   sz [2];
      logic [69:0] f;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        r_fl[k] = ($urandom_range(0, 49) == 0);
        if (!pend[k]) begin
          r_iv[k] = ($urandom_range(0, 99) < 60);
          r_alu[k] = $urandom;
          r_mwd[k] = $urandom;
          r_mwe[k] = 1'($urandom);
          r_wbe[k] = 1'($urandom);
          r_dest[k] = 3'($urandom);
          r_mux[k] = 1'($urandom);
        end
        r_ordy[k] = ($urandom_range(0, 99) < 50);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        sz[k] = qsize(k);
        f = (sz[k] != 0) ? qfront(k) : 70'd0;
        exp_rdy[k] = (k == 1) ? (sz[k] < 2) : (sz[k] == 0 || r_ordy[k]);
        chk($sformatf("rand%0d out_valid", k), 128'(r_ov[k]), 128'(sz[k] != 0));
        if (sz[k] != 0)
          chk($sformatf("rand%0d bundle", k), 128'(r_bun[k]), 128'(f));
        chk($sformatf("rand%0d bundle enables", k), 128'({r_bun[k][37], r_bun[k][4]}), 128'({f[37], f[4]}));
        chk($sformatf("rand%0d out_mem_we", k), 128'(r_omwe[k]), 128'(f[37]));
        chk($sformatf("rand%0d out_wb_en", k), 128'(r_owbe[k]), 128'(f[4]));
        chk($sformatf("rand%0d stall", k), 128'(r_st[k]), 128'(cnt[k]));
        chk($sformatf("rand%0d in_ready", k), 128'(r_rdy[k]), 128'(exp_rdy[k]));
        acc[k] = r_iv[k] && exp_rdy[k];
      end
      r_ordy[1] = !r_ordy[1];
      #1;
      chk("rand1 in_ready vs out_ready", 128'(r_rdy[1]), 128'(exp_rdy[1]));
      r_ordy[1] = !r_ordy[1];
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!r_fl[k] && sz[k] != 0 && !r_ordy[k] && cnt[k] < 15) cnt[k]++;
        if (r_fl[k]) begin
          qclear(k);
        end else begin
          if (sz[k] != 0 && r_ordy[k]) qpop(k);
          if (acc[k]) qpush(k, {r_alu[k], r_mwe[k], r_mwd[k], r_wbe[k], r_dest[k], r_mux[k]});
        end
        pend[k] = r_iv[k] && !acc[k] && !r_fl[k];
      end
    end

    #1;
    chk("rand0 stall saturated", 128'(r_st[0]), 128'(4'd15));
    chk("rand1 stall saturated", 128'(r_st[1]), 128'(4'd15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
